// File: rtl/csr_trap_cause.sv
// Trap-cause CSR unit: prioritised exception/interrupt select, mcause/mtval capture, handler FSM, double-fault flag.
// Latency: trap_o one cycle after the request; CSR reads combinational. No backpressure: requests are level-sampled.
// Optional trap counter at 0x7C0 when CSR_TRAP_COUNT_EN is defined.
module csr_trap_cause #(
    parameter int XLEN    = 32,
    parameter int NUM_EXC = 4,
    parameter int NUM_IRQ = 3,
    parameter int CODE_W  = 5,
    parameter logic [NUM_EXC*CODE_W-1:0] EXC_CODES = {5'd3, 5'd11, 5'd2, 5'd0},
    parameter logic [NUM_IRQ*CODE_W-1:0] IRQ_CODES = {5'd3, 5'd7, 5'd11}
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [11:0]             addr_i,
    input  logic [XLEN-1:0]         set_i,
    input  logic [XLEN-1:0]         clear_i,
    output logic                    ack_o,
    output logic [XLEN-1:0]         value_o,
    input  logic [NUM_EXC-1:0]      exc_valid_i,
    input  logic [NUM_EXC*XLEN-1:0] exc_tval_i,
    input  logic [NUM_IRQ-1:0]      irq_i,
    input  logic [NUM_IRQ-1:0]      irq_en_i,
    input  logic                    mret_i,
    output logic                    trap_o,
    output logic [XLEN-1:0]         trap_cause_o,
    output logic                    in_trap_o,
    output logic                    double_fault_o
);
    localparam logic [11:0] ADDR_MCAUSE = 12'h342;
    localparam logic [11:0] ADDR_MTVAL  = 12'h343;
    localparam logic [XLEN-1:0] MCAUSE_MASK = {1'b1, {(XLEN-1-CODE_W){1'b0}}, {CODE_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, TRAP, HANDLER} state_t;

    state_t             state;
    logic [XLEN-1:0]    mcause;
    logic [XLEN-1:0]    mtval;
    logic               exc_any;
    logic [NUM_IRQ-1:0] irq_pend;
    logic [CODE_W-1:0]  exc_code;
    logic [CODE_W-1:0]  irq_code;
    logic [XLEN-1:0]    exc_tval;
    logic [XLEN-1:0]    sel_cause;
    logic [XLEN-1:0]    sel_tval;
    logic               take;
    logic               hit_cause;
    logic               hit_tval;
    logic               hit_cnt;

    // Code tables are listed highest-priority source first (leftmost slice = index 0).
    always_comb begin
        exc_any  = |exc_valid_i;
        irq_pend = irq_i & irq_en_i;
        exc_code = '0;
        exc_tval = '0;
        irq_code = '0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (exc_valid_i[i]) begin
                exc_code = EXC_CODES[(NUM_EXC-1-i)*CODE_W +: CODE_W];
                exc_tval = exc_tval_i[i*XLEN +: XLEN];
            end
        end
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (irq_pend[k]) begin
                irq_code = IRQ_CODES[(NUM_IRQ-1-k)*CODE_W +: CODE_W];
            end
        end
        sel_cause               = '0;
        sel_cause[CODE_W-1:0]   = exc_any ? exc_code : irq_code;
        sel_cause[XLEN-1]       = ~exc_any;
        sel_tval                = exc_any ? exc_tval : '0;
        take = ((state == IDLE) && (exc_any || (|irq_pend))) ||
               ((state == HANDLER) && exc_any);
    end

`ifdef CSR_TRAP_COUNT_EN
    localparam logic [11:0] ADDR_TCNT = 12'h7C0;
    logic [31:0] trap_cnt;
    assign hit_cnt = (addr_i == ADDR_TCNT);
`else
    assign hit_cnt = 1'b0;
`endif

    assign hit_cause    = (addr_i == ADDR_MCAUSE);
    assign hit_tval     = (addr_i == ADDR_MTVAL);
    assign ack_o        = en_i && (hit_cause || hit_tval || hit_cnt);
    assign trap_cause_o = mcause;

    always_comb begin
        value_o = '0;
        if (ack_o && hit_cause) value_o = mcause;
        if (ack_o && hit_tval)  value_o = mtval;
`ifdef CSR_TRAP_COUNT_EN
        if (ack_o && hit_cnt)   value_o = XLEN'(trap_cnt);
`endif
    end

    // A trap capture in the same cycle as a CSR write to mcause/mtval discards the write.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state          <= IDLE;
            mcause         <= '0;
            mtval          <= '0;
            trap_o         <= 1'b0;
            in_trap_o      <= 1'b0;
            double_fault_o <= 1'b0;
        end else begin
            trap_o <= take;
            if (take) begin
                mcause <= sel_cause;
                mtval  <= sel_tval;
            end else begin
                if (ack_o && hit_cause) mcause <= (mcause | set_i) & ~clear_i & MCAUSE_MASK;
                if (ack_o && hit_tval)  mtval  <= (mtval | set_i) & ~clear_i;
            end
            case (state)
                IDLE: begin
                    if (take) begin
                        state     <= TRAP;
                        in_trap_o <= 1'b1;
                    end
                end
                TRAP: state <= HANDLER;
                HANDLER: begin
                    if (exc_any) begin
                        double_fault_o <= 1'b1;
                    end else if (mret_i) begin
                        state     <= IDLE;
                        in_trap_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_trap_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef CSR_TRAP_COUNT_EN
    // A CSR write outranks the increment of the same cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            trap_cnt <= '0;
        end else if (ack_o && hit_cnt) begin
            trap_cnt <= (trap_cnt | set_i[31:0]) & ~clear_i[31:0];
        end else if (trap_o && (trap_cnt != 32'hFFFF_FFFF)) begin
            trap_cnt <= trap_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_csr_trap_cause.sv
// Randomised bench for csr_trap_cause with a behavioural reference model and directed anchor checks.
module tb_csr_trap_cause;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         en_i;
    logic [11:0]  addr_i;
    logic [31:0]  set_i;
    logic [31:0]  clear_i;
    logic         ack_o;
    logic [31:0]  value_o;
    logic [3:0]   exc_valid_i;
    logic [127:0] exc_tval_i;
    logic [2:0]   irq_i;
    logic [2:0]   irq_en_i;
    logic         mret_i;
    logic         trap_o;
    logic [31:0]  trap_cause_o;
    logic         in_trap_o;
    logic         double_fault_o;

    always #5 clk_i = ~clk_i;

    csr_trap_cause dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .addr_i(addr_i),
        .set_i(set_i), .clear_i(clear_i), .ack_o(ack_o), .value_o(value_o),
        .exc_valid_i(exc_valid_i), .exc_tval_i(exc_tval_i),
        .irq_i(irq_i), .irq_en_i(irq_en_i), .mret_i(mret_i),
        .trap_o(trap_o), .trap_cause_o(trap_cause_o),
        .in_trap_o(in_trap_o), .double_fault_o(double_fault_o)
    );

    int exc_codes [4] = '{3, 11, 2, 0};
    int irq_codes [3] = '{3, 7, 11};

    // Model state: 0 idle, 1 just trapped, 2 in handler.
    int          m_st;
    logic [31:0] m_cause, m_tval, m_cnt;
    logic        m_trap, m_df;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_st = 0; m_cause = 0; m_tval = 0; m_cnt = 0; m_trap = 0; m_df = 0;
    endtask

    function automatic bit has_cnt();
`ifdef CSR_TRAP_COUNT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk_regs();
        chk("trap_o", {31'd0, trap_o}, {31'd0, m_trap});
        chk("mcause", trap_cause_o, m_cause);
        chk("in_trap", {31'd0, in_trap_o}, {31'd0, m_st != 0});
        chk("double_fault", {31'd0, double_fault_o}, {31'd0, m_df});
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        logic        ex_ack, take, wr;
        logic [31:0] ex_val, n_cause, n_tval, n_cnt;
        int          ei, ii, n_st;
        #1;
        ex_ack = en_i && (addr_i == 12'h342 || addr_i == 12'h343 ||
                          (has_cnt() && addr_i == 12'h7C0));
        ex_val = 0;
        if (ex_ack) ex_val = (addr_i == 12'h342) ? m_cause : (addr_i == 12'h343) ? m_tval : m_cnt;
        chk("ack", {31'd0, ack_o}, {31'd0, ex_ack});
        chk("rdata", value_o, ex_val);

        ei = -1; ii = -1;
        for (int i = 0; i < 4; i++) if (exc_valid_i[i] && ei < 0) ei = i;
        for (int k = 0; k < 3; k++) if (irq_i[k] && irq_en_i[k] && ii < 0) ii = k;
        take = (m_st == 0 && (ei >= 0 || ii >= 0)) || (m_st == 2 && ei >= 0);
        n_cause = m_cause; n_tval = m_tval; n_cnt = m_cnt; n_st = m_st;
        if (take) begin
            n_cause = (ei >= 0) ? exc_codes[ei] : (32'h8000_0000 + irq_codes[ii]);
            n_tval  = (ei >= 0) ? exc_tval_i[ei*32 +: 32] : 32'd0;
        end else begin
            if (ex_ack && addr_i == 12'h342) n_cause = (m_cause | set_i) & ~clear_i & 32'h8000_001F;
            if (ex_ack && addr_i == 12'h343) n_tval = (m_tval | set_i) & ~clear_i;
        end
        wr = ex_ack && addr_i == 12'h7C0;
        if (wr) n_cnt = (m_cnt | set_i) & ~clear_i;
        else if (m_trap && m_cnt != 32'hFFFF_FFFF) n_cnt = m_cnt + 1;
        if (m_st == 0 && take) n_st = 1;
        else if (m_st == 1) n_st = 2;
        else if (m_st == 2 && ei < 0 && mret_i) n_st = 0;
        @(posedge clk_i);
        if (m_st == 2 && ei >= 0) m_df = 1;
        m_trap = take; m_cause = n_cause; m_tval = n_tval; m_cnt = n_cnt; m_st = n_st;
        @(negedge clk_i);
        chk_regs();
    endtask

    task automatic idle_inputs();
        en_i = 0; addr_i = 0; set_i = 0; clear_i = 0; exc_valid_i = 0;
        irq_i = 0; irq_en_i = 0; mret_i = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        #1;
        m_reset();
        chk_regs();
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        idle_inputs();
        exc_tval_i = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
        rst_i = 1'b1;
        @(negedge clk_i);
        do_reset();
        chk("rst_mcause", trap_cause_o, 32'h0);

        en_i = 1; addr_i = 12'h342; #1;
        chk("rd342_ack", {31'd0, ack_o}, 32'd1); chk("rd342", value_o, 32'h0);
        tick();
        addr_i = 12'h343; #1;
        chk("rd343_ack", {31'd0, ack_o}, 32'd1); chk("rd343", value_o, 32'h0);
        tick();
        addr_i = 12'h341; #1;
        chk("rd341_ack", {31'd0, ack_o}, 32'd0); chk("rd341", value_o, 32'h0);
        tick();

        // Exception 1 wins over 2.
        idle_inputs(); exc_valid_i = 4'b0110;
        tick();
        chk("exc_trap", {31'd0, trap_o}, 32'd1);
        chk("exc_cause", trap_cause_o, 32'h0000_000B);
        chk("exc_intrap", {31'd0, in_trap_o}, 32'd1);
        exc_valid_i = 0; en_i = 1; addr_i = 12'h343; #1;
        chk("exc_tval", value_o, 32'hDEAD_BEEF);
        tick();
        idle_inputs(); mret_i = 1;
        tick();
        mret_i = 0;

        irq_i = 3'b011; irq_en_i = 3'b010;
        tick();
        chk("irq_cause", trap_cause_o, 32'h8000_0007);
        en_i = 1; addr_i = 12'h343; #1;
        chk("irq_tval", value_o, 32'h0);
        tick();
        en_i = 0;
        tick();
        chk("irq_in_handler", {31'd0, trap_o}, 32'd0);

        exc_valid_i = 4'b0001;
        tick();
        chk("nest_cause", trap_cause_o, 32'h0000_0003);
        chk("nest_df", {31'd0, double_fault_o}, 32'd1);
        idle_inputs(); mret_i = 1;
        tick();
        chk("mret_idle", {31'd0, in_trap_o}, 32'd0);
        chk("df_sticky", {31'd0, double_fault_o}, 32'd1);

        idle_inputs(); en_i = 1; addr_i = 12'h342; set_i = 32'hFFFF_FFFF; clear_i = 32'h10;
        tick();
        set_i = 0; clear_i = 0; #1;
        chk("warl", value_o, 32'h8000_000F);
        set_i = 32'hFFFF_FFFF; clear_i = 32'h10; exc_valid_i = 4'b0100;
        tick();
        chk("collide", trap_cause_o, 32'h0000_0002);
        idle_inputs();
        tick();
        mret_i = 1;
        tick();
        idle_inputs();

`ifdef CSR_TRAP_COUNT_EN
        en_i = 1; addr_i = 12'h7C0; clear_i = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        for (int n = 0; n < 3; n++) begin
            exc_valid_i = 4'b1000; tick();
            exc_valid_i = 0; tick();
            mret_i = 1; tick(); mret_i = 0;
        end
        en_i = 1; addr_i = 12'h7C0; #1;
        chk("cnt3", value_o, 32'd3);
        set_i = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        exc_valid_i = 4'b1000; tick();
        exc_valid_i = 0; tick();
        mret_i = 1; tick(); mret_i = 0;
        en_i = 1; addr_i = 12'h7C0; #1;
        chk("cnt_sat", value_o, 32'hFFFF_FFFF);
        tick();
        idle_inputs();
`else
        en_i = 1; addr_i = 12'h7C0; #1;
        chk("cnt_absent_ack", {31'd0, ack_o}, 32'd0);
        chk("cnt_absent_val", value_o, 32'h0);
        tick();
        idle_inputs();
`endif

        // Reset asserted while in the handler with double fault set.
        exc_valid_i = 4'b0001; tick();
        exc_valid_i = 0; tick();
        exc_valid_i = 4'b0010; tick();
        idle_inputs();
        do_reset();
        chk("rst_mid_intrap", {31'd0, in_trap_o}, 32'd0);
        chk("rst_mid_df", {31'd0, double_fault_o}, 32'd0);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                idle_inputs();
                do_reset();
                continue;
            end
            en_i = $urandom_range(0, 1);
            case ($urandom_range(0, 4))
                0: addr_i = 12'h341;
                1: addr_i = 12'h342;
                2: addr_i = 12'h343;
                3: addr_i = 12'h7C0;
                default: addr_i = 12'($urandom);
            endcase
            set_i       = ($urandom_range(0, 2) == 0) ? $urandom : 32'd0;
            clear_i     = ($urandom_range(0, 2) == 0) ? $urandom : 32'd0;
            exc_valid_i = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
            exc_tval_i  = {$urandom, $urandom, $urandom, $urandom};
            irq_i       = 3'($urandom);
            irq_en_i    = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0;
            mret_i      = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
